// File: rtl/array_mult_pkg.sv
// Shared types and constants for the shared array-multiplier arbiter.
package array_mult_pkg;

    // The multiplier instance is fixed at 4x4.
    localparam int unsigned MULT_W = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StHold = 2'd2
    } state_e;

    // Width of a requester index.
    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/array_mult_structural.sv
// 4x4 unsigned array multiplier: rows of full adders accumulate shifted partial products.
module array_mult_structural (
    input  logic [3:0] m,
    input  logic [3:0] q,
    output logic [7:0] p
);

    // One ripple-carry row per multiplier bit.
    always_comb begin
        logic [7:0] acc;
        logic [7:0] addend;
        logic [7:0] nxt;
        logic       c;
        acc    = '0;
        addend = '0;
        nxt    = '0;
        c      = 1'b0;
        for (int r = 0; r < 4; r++) begin
            addend = {4'b0000, m & {4{q[r]}}} << r;
            c      = 1'b0;
            for (int b = 0; b < 8; b++) begin
                nxt[b] = acc[b] ^ addend[b] ^ c;
                c      = (acc[b] & addend[b]) | (c & (acc[b] ^ addend[b]));
            end
            acc = nxt;
        end
        p = acc;
    end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx
);

    // Scan ptr, ptr+1, ... modulo NREQ and keep the first hit.
    always_comb begin
        int unsigned idx;
        logic        found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/array_mult_arbiter.sv
// Shares one 4x4 multiplier among NREQ requesters: round-robin accept, multiply, hold result.
module array_mult_arbiter
    import array_mult_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = MULT_W,
    localparam int unsigned IDW = id_width(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_m,
    input  logic [NREQ*W-1:0] req_q,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [2*W-1:0]    rsp_p,
    output logic [IDW-1:0]    rsp_id,
    output logic              busy
);

    localparam logic [IDW-1:0] LastIdx = IDW'(NREQ - 1);

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [W-1:0]     op_m_q, op_m_d;
    logic [W-1:0]     op_q_q, op_q_d;
    logic [IDW-1:0]   op_id_q, op_id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [2*W-1:0]   rsp_p_q, rsp_p_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;

    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   gnt_idx;
    logic [2*W-1:0]   prod;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    array_mult_structural u_mult (
        .m (op_m_q),
        .q (op_q_q),
        .p (prod)
    );

    // Next-state, operand capture and response update.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        op_m_d      = op_m_q;
        op_q_d      = op_q_q;
        op_id_d     = op_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_p_d     = rsp_p_q;
        rsp_id_d    = rsp_id_q;
        req_ready   = '0;
        unique case (state_q)
            StIdle: begin
                // Ready is gated by rst so nothing looks accepted while reset is asserted.
                req_ready = rst ? '0 : gnt;
                if (|(req_valid & req_ready)) begin
                    op_m_d  = req_m[gnt_idx*W +: W];
                    op_q_d  = req_q[gnt_idx*W +: W];
                    op_id_d = gnt_idx;
                    ptr_d   = (gnt_idx == LastIdx) ? '0 : gnt_idx + 1'b1;
                    state_d = StMul;
                end
            end
            StMul: begin
                rsp_p_d     = prod;
                rsp_id_d    = op_id_q;
                rsp_valid_d = 1'b1;
                state_d     = StHold;
            end
            StHold: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            op_m_q      <= '0;
            op_q_q      <= '0;
            op_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_p_q     <= '0;
            rsp_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            op_m_q      <= op_m_d;
            op_q_q      <= op_q_d;
            op_id_q     <= op_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_p_q     <= rsp_p_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_p     = rsp_p_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != StIdle);

endmodule
